// File: rtl/bf_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N_IN-input boolean function block: drives every vector,
// samples the result after a settle window and compares the truth table. Define BF_SWEEP_GRAY_EN for Gray-order vectors.
module bf_sweep_ctrl #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      f_in,
  input  logic                 f_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt,
  output logic                 pass,
  output logic [N_IN:0]        mism_cnt
);

  localparam int unsigned NV = 2**N_IN;
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN:0]   LAST_VEC = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0]   VEC_ONE  = {{N_IN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_e;

  state_e          state_q, state_d;
  logic [N_IN:0]   vec_q, vec_d, vec_nxt;
  logic [3:0]      set_q, set_d;
  logic [N_IN-1:0] f_in_q, f_in_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   mism_q, mism_d;
  logic [N_IN:0]   popc;

  // The vector counter indexes the sweep slot; f_in is the value actually applied.
  function automatic logic [N_IN-1:0] vec2in(input logic [N_IN:0] v);
`ifdef BF_SWEEP_GRAY_EN
    return v[N_IN-1:0] ^ (v[N_IN-1:0] >> 1);
`else
    return v[N_IN-1:0];
`endif
  endfunction

  always_comb begin
    popc = '0;
    for (int unsigned i = 0; i < NV; i++) begin
      popc = popc + {{N_IN{1'b0}}, tt_q[i] ^ exp_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    set_d   = set_q;
    f_in_d  = f_in_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mism_d  = mism_q;
    vec_nxt = vec_q + VEC_ONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          tt_d    = '0;
          pass_d  = 1'b0;
          mism_d  = '0;
          vec_d   = '0;
          set_d   = '0;
          f_in_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Last edge of a slot both samples the current vector and applies the next one.
        if (set_q == SETTLE_C) begin
          tt_d[f_in_q] = f_out;
          set_d        = '0;
          if (vec_q == LAST_VEC) begin
            vec_d   = '0;
            f_in_d  = '0;
            state_d = CHECK;
          end else begin
            vec_d  = vec_nxt;
            f_in_d = vec2in(vec_nxt);
          end
        end else begin
          set_d = set_q + 4'd1;
        end
      end
      CHECK: begin
        pass_d  = (tt_q == exp_q);
        mism_d  = popc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      set_q   <= '0;
      f_in_q  <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mism_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
      f_in_q  <= f_in_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mism_q  <= mism_d;
    end
  end

  assign f_in     = f_in_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign tt       = tt_q;
  assign pass     = pass_q;
  assign mism_cnt = mism_q;

endmodule
